// File: rtl/reaction_timer.sv
// Reaction-game round controller: random pre-GO delay, then counts ms until the
// debounced button is pressed; reports result, false start or timeout.
module reaction_timer #(
  parameter int          CLK_PER_MS   = 50000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          MAX_MS       = 9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_in,
  output logic        led_go,
  output logic [13:0] result_ms,
  output logic        result_valid,
  output logic        false_start,
  output logic        busy
);

  localparam int              PW         = $clog2(CLK_PER_MS);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_PER_MS - 1);
  localparam logic [13:0]     MS_MAX     = 14'(MAX_MS);
  localparam logic [13:0]     MS_SAT     = 14'(MAX_MS - 1);
  localparam logic [10:0]     MIN_D      = 11'(MIN_DELAY_MS);

  typedef enum logic [1:0] {IDLE, ARM, GO, DONE} state_t;

  state_t        state;
  logic          btn_q;
  logic          press;
  logic [15:0]   lfsr;
  logic          lfsr_fb;
  logic [PW-1:0] presc;
  logic          tick;
  logic [13:0]   ms_cnt;
  logic [10:0]   delay_ms;
  logic [13:0]   delay_last;

  assign press      = btn_in & ~btn_q;
  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign tick       = (presc == PRESC_LAST);
  assign delay_last = {3'b000, delay_ms} - 14'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      btn_q        <= 1'b1;
      lfsr         <= LFSR_SEED;
      presc        <= '0;
      ms_cnt       <= '0;
      delay_ms     <= '0;
      led_go       <= 1'b0;
      result_ms    <= '0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      btn_q        <= btn_in;
      lfsr         <= {lfsr[14:0], lfsr_fb};
      result_valid <= 1'b0;
      presc        <= tick ? '0 : presc + 1'b1;

      case (state)
        IDLE, DONE: begin
          if (press) begin
            state       <= ARM;
            delay_ms    <= MIN_D + {1'b0, lfsr[9:0]};
            ms_cnt      <= '0;
            presc       <= '0;
            busy        <= 1'b1;
            false_start <= 1'b0;
          end
        end

        ARM: begin
          // A press on the expiry tick still counts as a false start.
          if (press) begin
            state       <= DONE;
            false_start <= 1'b1;
            busy        <= 1'b0;
            presc       <= '0;
          end else if (tick) begin
            if (ms_cnt == delay_last) begin
              state  <= GO;
              ms_cnt <= '0;
              led_go <= 1'b1;
              presc  <= '0;
            end else begin
              ms_cnt <= ms_cnt + 14'd1;
            end
          end
        end

        GO: begin
          // Press reports completed ms only, so it wins over a coincident tick.
          if (press) begin
            state        <= DONE;
            result_ms    <= ms_cnt;
            result_valid <= 1'b1;
            led_go       <= 1'b0;
            busy         <= 1'b0;
            presc        <= '0;
          end else if (tick) begin
            if (ms_cnt == MS_SAT) begin
              state        <= DONE;
              result_ms    <= MS_MAX;
              result_valid <= 1'b1;
              led_go       <= 1'b0;
              busy         <= 1'b0;
              presc        <= '0;
            end else begin
              ms_cnt <= ms_cnt + 14'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer: table of rounds plus reset sequences.
module tb_reaction_timer;

  localparam int CPM  = 4;
  localparam int MIND = 2;
  localparam int MAXM = 20;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_in;
  logic        led_go;
  logic [13:0] result_ms;
  logic        result_valid;
  logic        false_start;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  reaction_timer #(
    .CLK_PER_MS(CPM), .MIN_DELAY_MS(MIND), .MAX_MS(MAXM), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .led_go(led_go),
    .result_ms(result_ms), .result_valid(result_valid),
    .false_start(false_start), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference LFSR, taps 16,14,13,11, shifting toward the MSB.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  // Any published result must never exceed the saturation value.
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      n_chk++;
      if (int'(result_ms) > MAXM) begin
        n_fail++;
        $display("FAIL result_ms_bound: got %0d, must be <= %0d", result_ms, MAXM);
      end
    end
  end

  typedef struct {
    int arm_press;  // >0: press this many cycles after ARM entry; -1: on expiry tick
    int go_press;   // >0: press this many cycles after GO entry; 0: let it time out
    int exp_ms;
    int exp_fs;
  } row_t;

  row_t rows[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic start_round(output int dly);
    btn_in = 1'b0;
    step();
    step();
    dly = MIND + int'(m_lfsr[9:0]);
    btn_in = 1'b1;
    step();
    btn_in = 1'b0;
    chk("arm_busy", int'(busy), 1);
    chk("arm_fs_clear", int'(false_start), 0);
    chk("arm_led_off", int'(led_go), 0);
  endtask

  task automatic run_row(input row_t r);
    int dly;
    int n;
    int target;
    start_round(dly);
    if (r.arm_press != 0) begin
      target = (r.arm_press > 0) ? r.arm_press : dly * CPM;
      for (int i = 1; i < target; i++) step();
      chk("arm_no_go_yet", int'(led_go), 0);
      btn_in = 1'b1;
      step();
      btn_in = 1'b0;
      chk("fs_flag", int'(false_start), r.exp_fs);
      chk("fs_led", int'(led_go), 0);
      chk("fs_busy", int'(busy), 0);
      chk("fs_no_valid", int'(result_valid), 0);
      chk("fs_ms_held", int'(result_ms), r.exp_ms);
      step();
      chk("fs_led_after", int'(led_go), 0);
      chk("fs_no_valid_after", int'(result_valid), 0);
      chk("fs_flag_held", int'(false_start), 1);
    end else begin
      n = 0;
      while (led_go !== 1'b1 && n < 5000) begin
        step();
        n++;
      end
      chk("go_onset_cycles", n, dly * CPM);
      chk("go_busy", int'(busy), 1);
      if (r.go_press > 0) begin
        for (int i = 1; i < r.go_press; i++) step();
        btn_in = 1'b1;
        step();
        btn_in = 1'b0;
      end else begin
        n = 0;
        while (result_valid !== 1'b1 && n < 200) begin
          step();
          n++;
        end
        chk("timeout_cycles", n, MAXM * CPM);
      end
      chk("res_valid", int'(result_valid), 1);
      chk("res_ms", int'(result_ms), r.exp_ms);
      chk("res_led_off", int'(led_go), 0);
      chk("res_busy_off", int'(busy), 0);
      chk("res_fs", int'(false_start), r.exp_fs);
      step();
      chk("res_valid_1cyc", int'(result_valid), 0);
      chk("res_ms_held", int'(result_ms), r.exp_ms);
    end
  endtask

  initial begin
    int dly;
    int n;

    rows[0] = '{arm_press: 0,  go_press: 13, exp_ms: 3,  exp_fs: 0};
    rows[1] = '{arm_press: 5,  go_press: 0,  exp_ms: 3,  exp_fs: 1};
    rows[2] = '{arm_press: 0,  go_press: 1,  exp_ms: 0,  exp_fs: 0};
    rows[3] = '{arm_press: -1, go_press: 0,  exp_ms: 0,  exp_fs: 1};
    rows[4] = '{arm_press: 0,  go_press: 0,  exp_ms: 20, exp_fs: 0};
    rows[5] = '{arm_press: 0,  go_press: 80, exp_ms: 19, exp_fs: 0};
    rows[6] = '{arm_press: 0,  go_press: 6,  exp_ms: 1,  exp_fs: 0};

    // Reset with the button held: no round may start.
    rst = 1'b1;
    btn_in = 1'b1;
    step(); step(); step();
    chk("rst_led", int'(led_go), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_fs", int'(false_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ms", int'(result_ms), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("held_btn_no_round", int'(busy), 0);
    btn_in = 1'b0;
    step(); step();
    chk("release_no_round", int'(busy), 0);

    for (int i = 0; i < 7; i++) run_row(rows[i]);

    // Reset in the middle of GO.
    start_round(dly);
    n = 0;
    while (led_go !== 1'b1 && n < 5000) begin
      step();
      n++;
    end
    chk("mid_go_onset", n, dly * CPM);
    step(); step(); step();
    rst = 1'b1;
    step();
    chk("midrst_led", int'(led_go), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(result_valid), 0);
    chk("midrst_fs", int'(false_start), 0);
    chk("midrst_ms", int'(result_ms), 0);
    chk("midrst_lfsr", int'(dut.lfsr), int'(SEED));
    rst = 1'b0;
    btn_in = 1'b0;
    step();
    chk("post_rst_idle", int'(busy), 0);
    run_row(rows[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
# reaction_timer

Reaction-time measurement controller for the reaction game. It sits directly downstream of the button debouncer and consumes its debounced, active-high button level. Each round it waits a pseudo-random delay, then lights the GO LED and counts milliseconds until the player presses. It reports the reaction time, a false start, or a timeout to the display logic.

## Interface
- `CLK_PER_MS`, default 50000: clock cycles per millisecond tick; must be ≥ 2.
- `MIN_DELAY_MS`, default 1000: fixed part of the pre-GO delay; must be ≤ 1024.
- `MAX_MS`, default 9999: saturation / timeout value for the reaction count; must be < 16384.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be non-zero.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `btn_in`  in  1  debounced button level from the debouncer's `sig_out`; 1 = pressed.
- `led_go`  out  1  GO indicator; high only in state GO.
- `result_ms`  out  14  last reaction time in ms; held until the next result.
- `result_valid`  out  1  one-cycle pulse when `result_ms` is updated.
- `false_start`  out  1  high from a false start until the next round starts.
- `busy`  out  1  high in states ARM and GO.

## Operation
- **Edge detect.** Register `btn_q <= btn_in`; `press = btn_in & ~btn_q`. `btn_q` resets to 1, so a button held through reset produces no press.
- **LFSR.** 16-bit Fibonacci LFSR with taps 16,14,13,11. It free-runs every cycle and resets to `LFSR_SEED`.
- **Delay sampling.** On each entry to ARM, `delay_ms = MIN_DELAY_MS + lfsr[9:0]`, using an 11-bit unsigned add.
- **Prescaler.** Counts 0..`CLK_PER_MS`-1. `tick` is high on the terminal count, after which the prescaler wraps to 0. It is forced to 0 on every state entry, so each ms is exactly `CLK_PER_MS` cycles from that entry.
- **FSM states:** IDLE, ARM, GO, DONE.
  - IDLE, on `press`: go to ARM. Clear `false_start`, sample the delay.
  - ARM, on `press`: go to DONE. Set `false_start`; `result_ms` is unchanged; no `result_valid`.
  - ARM, on `tick` with ms count == `delay_ms`-1: go to GO. Clear the ms counter.
  - GO, on `tick`: ms counter += 1.
  - GO, on `press`: go to DONE. Load `result_ms` with the current ms counter (completed ms only) and pulse `result_valid`.
  - GO, ms counter reaches `MAX_MS`: go to DONE. Load `result_ms = MAX_MS` and pulse `result_valid`. This is the timeout; no wrap.
  - DONE, on `press`: go to ARM. Starts a new round: clear `false_start`, resample the delay.
- **Simultaneous events.**
  - `press` and the delay-expiry `tick` in the same ARM cycle: the press wins, giving a false start.
  - `press` and the saturating `tick` in the same GO cycle: the press wins, and `result_ms` = the counter value before the increment.
- **Reset.** `rst` takes priority over everything, at any point mid-round. It returns the FSM to IDLE.
  - All outputs go to 0.
  - Internal state resets: prescaler 0, ms counter 0, LFSR to `LFSR_SEED`, `btn_q` to 1.

## Timing
- All outputs are registered and change only on the rising edge of `clk`.
- **Press latency.** `btn_in` rises between edges n-1 and n. The FSM transitions at edge n, and outputs reflect the new state after edge n.
- **GO onset.** `led_go` rises exactly `delay_ms`×`CLK_PER_MS` cycles after the ARM entry edge.
- **Result.** `result_ms` = floor((press edge − GO entry edge) / `CLK_PER_MS`), saturating at `MAX_MS`.
- **Pulses and flags.**
  - `result_valid` is high for exactly the one cycle following the DONE entry edge.
  - `led_go` and `busy` drop on that same edge.
- **Reset values.** `led_go`, `result_valid`, `false_start` and `busy` reset to 0; `result_ms` resets to 14'd0.

## Test plan
Use `CLK_PER_MS`=4, `MIN_DELAY_MS`=2, `MAX_MS`=20 unless stated otherwise.

1. **Reset with button held.** Assert `rst` with `btn_in`=1, then release both. Required: stays IDLE; all outputs 0; no round starts until `btn_in` falls and rises again.
2. **Normal round.** Press from IDLE. Required: `led_go` rises exactly (2+lfsr[9:0])×4 cycles after ARM entry, checked against a reference-model LFSR. Press 13 cycles after GO entry. Required: `result_ms`=3, `result_valid` high for 1 cycle, `led_go` and `busy` low.
3. **False start.** Press during ARM. Required: `false_start`=1, no `result_valid`, `result_ms` keeps its previous value. A press from DONE clears `false_start` and re-enters ARM.
4. **Timeout.** Enter GO with no press. Required: after 20×4 cycles `result_ms`=20 and `result_valid` pulses once; no value above 20 ever appears.
5. **Tie cases.** Press coincident with the delay-expiry tick. Required: false start, and `led_go` never asserts. Press coincident with the tick that reaches `MAX_MS`. Required: `result_ms`=19.
6. **Reset mid-GO.** Assert `rst` in GO. Required: next cycle IDLE, all outputs 0, LFSR = `LFSR_SEED`; the next round's delay matches the delay computed from the seed.
